// File: rtl/ring_osc_tuner.sv
// Ring-oscillator frequency tuner: counts synchronized gen_i edges over a fixed
// window and steps freq_sel_o until the count sits within TOL of target_i.
module ring_osc_tuner #(
  parameter int COUNT_WIDTH   = 12,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int TOL           = 2
) (
  input  logic                   fpga_clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   gen_i,
  input  logic [COUNT_WIDTH-1:0] target_i,
  output logic [3:0]             freq_sel_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   locked_o,
  output logic                   sat_o
);

  localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0]          WIN_LOAD = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0]          SET_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]          T_ONE    = TW'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH:0]   TOL_EXT  = (COUNT_WIDTH + 1)'(TOL);
  localparam logic [COUNT_WIDTH:0]   MAX_EXT  = {1'b0, CNT_MAX};

  // state   | meaning
  // IDLE    | disabled, waiting for enable_i
  // SETTLE  | let the oscillator settle after a code change
  // MEASURE | count gen_i edges over one window
  // ADJUST  | compare count_o with target, step code or lock
  // LOCKED  | back-to-back windows, one miss forgiven
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, ADJUST, LOCKED} state_t;

  state_t                 state;
  logic [TW-1:0]          timer;
  logic [COUNT_WIDTH-1:0] edges;
  logic                   miss;
  logic                   s1, s2, s3;
  logic                   rise;

  logic [COUNT_WIDTH-1:0] edges_next;
  logic [COUNT_WIDTH-1:0] cmp_val;
  logic [COUNT_WIDTH:0]   tgt_ext, lo_ext, hi_ext, hi_c;
  logic                   too_low, too_high, in_tol;
  logic [3:0]             freq_adj;
  logic                   at_limit;

  assign rise = s2 & ~s3;

  always_comb begin
    edges_next = edges;
    if (rise && (edges != CNT_MAX)) edges_next = edges + CNT_ONE;
  end

  // LOCKED judges the window that is closing this cycle, ADJUST judges count_o
  always_comb begin
    cmp_val  = (state == LOCKED) ? edges_next : count_o;
    tgt_ext  = {1'b0, target_i};
    lo_ext   = (tgt_ext >= TOL_EXT) ? (tgt_ext - TOL_EXT) : '0;
    hi_ext   = tgt_ext + TOL_EXT;
    hi_c     = (hi_ext > MAX_EXT) ? MAX_EXT : hi_ext;
    too_low  = ({1'b0, cmp_val} < lo_ext);
    too_high = ({1'b0, cmp_val} > hi_c);
    in_tol   = ~too_low & ~too_high;
  end

  always_comb begin
    freq_adj = freq_sel_o;
    at_limit = 1'b0;
    if (too_low) begin
      if (freq_sel_o == 4'd15) at_limit = 1'b1;
      else                     freq_adj = freq_sel_o + 4'd1;
    end else if (too_high) begin
      if (freq_sel_o == 4'd0)  at_limit = 1'b1;
      else                     freq_adj = freq_sel_o - 4'd1;
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      timer      <= '0;
      edges      <= '0;
      miss       <= 1'b0;
      freq_sel_o <= 4'd8;
      count_o    <= '0;
      locked_o   <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      s1 <= gen_i;
      s2 <= s1;
      s3 <= s2;
      if (!enable_i) begin
        state    <= IDLE;
        timer    <= '0;
        edges    <= '0;
        miss     <= 1'b0;
        locked_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SETTLE;
            timer <= SET_LOAD;
          end
          SETTLE: begin
            if (timer == '0) begin
              state <= MEASURE;
              timer <= WIN_LOAD;
              edges <= '0;
            end else begin
              timer <= timer - T_ONE;
            end
          end
          MEASURE: begin
            if (timer == '0) begin
              count_o <= edges_next;
              state   <= ADJUST;
            end else begin
              timer <= timer - T_ONE;
              edges <= edges_next;
            end
          end
          ADJUST: begin
            if (in_tol) begin
              locked_o <= 1'b1;
              sat_o    <= 1'b0;
              miss     <= 1'b0;
              state    <= LOCKED;
              timer    <= WIN_LOAD;
              edges    <= '0;
            end else begin
              freq_sel_o <= freq_adj;
              if (at_limit) sat_o <= 1'b1;
              state <= SETTLE;
              timer <= SET_LOAD;
            end
          end
          LOCKED: begin
            if (timer == '0) begin
              count_o <= edges_next;
              edges   <= '0;
              timer   <= WIN_LOAD;
              if (in_tol) begin
                miss <= 1'b0;
              end else if (!miss) begin
                miss <= 1'b1;
              end else begin
                miss       <= 1'b0;
                locked_o   <= 1'b0;
                freq_sel_o <= freq_adj;
                if (at_limit) sat_o <= 1'b1;
                state <= SETTLE;
                timer <= SET_LOAD;
              end
            end else begin
              timer <= timer - T_ONE;
              edges <= edges_next;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
